// File: rtl/var_delay_line_pkg.sv
// var_delay_line_pkg: shared helpers for the run-time programmable delay line.
package var_delay_line_pkg;
  function automatic int unsigned clamp_len(input int unsigned v, input int unsigned m);
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/dp_ram_1w1r.sv
// dp_ram_1w1r: DW x DEPTH RAM with synchronous write and asynchronous read.
module dp_ram_1w1r #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/var_delay_line.sv
// var_delay_line: circular-buffer delay line whose tap is set at run time by dly.
module var_delay_line
  import var_delay_line_pkg::*;
#(
  parameter int DW     = 8,
  parameter int MAXLEN = 16,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [LW-1:0] dly,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic          out_valid
);
  localparam int AW = $clog2(MAXLEN);
  logic [AW-1:0] wptr, tap, off;
  logic [LW-1:0] fill, fill_next, d_eff;
  logic [DW-1:0] rd, out_r;
  logic          vld_r, hit;
  assign d_eff     = LW'(clamp_len(32'(dly), MAXLEN));
  assign fill_next = fill == LW'(MAXLEN) ? fill : fill + 1'b1;
  assign off       = AW'(d_eff - 1'b1);
  assign tap       = wptr - off + (wptr < off ? AW'(MAXLEN) : '0);
  assign hit       = fill_next >= d_eff;
  dp_ram_1w1r #(.DW(DW), .DEPTH(MAXLEN)) u_ram (
    .clk(clk), .we(en), .waddr(wptr), .wdata(in), .raddr(tap), .rdata(rd)
  );
  // d_eff=1 taps the entry being written this edge, so take it straight from in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      fill  <= '0;
      out_r <= '0;
      vld_r <= 1'b0;
    end else if (en) begin
      wptr  <= wptr == AW'(MAXLEN - 1) ? '0 : wptr + 1'b1;
      fill  <= fill_next;
      vld_r <= hit;
      out_r <= !hit ? '0 : d_eff <= LW'(1) ? in : rd;
    end
  end
  assign out       = d_eff == '0 ? in : out_r;
  assign out_valid = d_eff == '0 ? 1'b1 : vld_r;
endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: scoreboard bench, driver pushes expectations, monitor pops and compares.
module tb_var_delay_line;
  typedef struct packed {logic v; logic [7:0] o;} exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [4:0] dly = '0;
  logic [7:0] in = '0;
  logic [7:0] out;
  logic       out_valid;
  exp_t       sb[$];
  exp_t       mon_e;
  int         hist[$];
  int         fill_m = 0;
  int         total = 0, bad = 0;
  logic [7:0] reg_o = '0;
  logic       reg_v = 1'b0;
  logic [15:0] pat = 16'hB6E5;

  var_delay_line dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dly(dly), .in(in), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got valid=%0b out=%0h, want valid=%0b out=%0h", nm, act[8], act[7:0], exp[8], exp[7:0]);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    fill_m = 0;
    reg_o = '0;
    reg_v = 1'b0;
  endtask

  task automatic step(input logic e, input int d, input int x);
    int de;
    exp_t ex;
    @(negedge clk);
    en = e; dly = 5'(d); in = 8'(x);
    de = d > 16 ? 16 : d;
    if (e) begin
      hist.push_back(x);
      fill_m = fill_m < 16 ? fill_m + 1 : 16;
      reg_v = fill_m >= de;
      reg_o = de == 0 ? 8'(x) : reg_v ? 8'(hist[hist.size() - de]) : 8'h00;
    end
    ex = de == 0 ? {1'b1, 8'(x)} : {reg_v, reg_o};
    sb.push_back(ex);
  endtask

  task automatic do_reset(input int d, input int x);
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; dly = 5'(d); in = 8'(x);
    @(negedge clk);
    chk($sformatf("reset_state dly=%0d", d), {out_valid, out}, d == 0 ? {1'b1, 8'(x)} : 9'h000);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk($sformatf("stream#%0d dly=%0d", total, dly), {out_valid, out}, mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(3, 8'h11);
    for (int i = 1; i <= 10; i++) step(1'b1, 3, i);
    do_reset(0, 8'h55);
    for (int i = 0; i < 10; i++) step(1'b1, 0, 8'h20 + i);
    for (int i = 0; i < 6; i++) step(1'b1, 4, 8'h30 + i);
    do_reset(20, 8'h01);
    for (int i = 0; i < 40; i++) step(1'b1, 20, 8'h40 + i);
    do_reset(5, 8'h02);
    for (int i = 0; i < 30; i++) step(pat[i % 16], 5, 8'h80 + i);
    do_reset(2, 8'h03);
    for (int i = 0; i < 8; i++) step(1'b1, 2, 8'hA0 + i);
    for (int i = 0; i < 6; i++) step(1'b1, 12, 8'hB0 + i);
    for (int i = 0; i < 3; i++) step(1'b1, 2, 8'hC0 + i);
    do_reset(3, 8'h04);
    for (int i = 0; i < 5; i++) step(1'b1, 3, 8'hD0 + i);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {out_valid, out}, 9'h000);
    #1 rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) step(1'b1, 3, 8'hE0 + i);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 9'(sb.size()), 9'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
